// File: rtl/ps_if_pkg.sv
// Shared constants, payload types and helpers for the ps_if pipeline slice.
package ps_if_pkg;

  localparam int PS_MAX_STAGES = 8;
  localparam int PS_ADDR_WIDTH = 32;
  localparam int PS_DATA_WIDTH = 32;

  // Default-width payloads; the slice builds width-parameterised copies of these.
  typedef struct packed {
    logic [PS_ADDR_WIDTH-1:0] addr;
    logic [PS_DATA_WIDTH-1:0] data;
  } ps_wreq_t;

  typedef struct packed {
    logic [PS_DATA_WIDTH-1:0] data;
  } ps_rdat_t;

  // Depth actually built: anything beyond the supported maximum is capped.
  function automatic int ps_clamp_stages(input int n);
    return (n > PS_MAX_STAGES) ? PS_MAX_STAGES : n;
  endfunction

endpackage

// File: rtl/ps_if.sv
// ps_if bus: write request + response, read address, read data.
interface ps_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  wresp;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  arvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output waddr, wdata, wvalid, raddr, arvalid, rready,
    input  wready, wresp, rdata, rvalid
  );

  modport slave (
    input  waddr, wdata, wvalid, raddr, arvalid, rready,
    output wready, wresp, rdata, rvalid
  );
endinterface

// File: rtl/ps_skid_stage.sv
// Two-entry valid/ready register stage (main + skid) with a registered in_ready.
module ps_skid_stage #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o,
  output logic busy_o
);

  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic ready_q;
  T     main_q, main_d;
  T     skid_q, skid_d;
  logic push, pop;

  // ready_q tracks !skid_valid_q (except right after reset), so a push never meets a full skid.
  assign push = in_valid_i && ready_q;
  assign pop  = main_valid_q && out_ready_i;

  // Main is the output register; skid catches a beat arriving while main is stalled and refills main first.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (pop || !main_valid_q) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = push;
        if (push) main_d = in_data_i;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_d       = in_data_i;
    end
  end

  // Control state: valid bits and the registered ready, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
    end
  end

  // Payload registers.
  // NOTE: data is not reset; the valid bits alone say whether it means anything.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;
  assign busy_o      = main_valid_q || skid_valid_q;

endmodule

// File: rtl/ps_if_pipe_slice.sv
// STAGES-deep ps_if register slice: skid chains on write and read-data, delay lines on
// read-address and wresp, entry gating by hold_valid, and a busy flag for quiesce logic.
module ps_if_pipe_slice
  import ps_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_valid,
  ps_if.slave  s_if,
  ps_if.master m_if,
  output logic busy
);

  localparam int NSTG = ps_clamp_stages(STAGES);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wreq_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
  } rdat_t;

  if (NSTG == 0) begin : g_pass
    assign m_if.waddr   = s_if.waddr;
    assign m_if.wdata   = s_if.wdata;
    assign m_if.wvalid  = hold_valid && s_if.wvalid;
    assign s_if.wready  = m_if.wready;
    assign s_if.wresp   = m_if.wresp;
    assign m_if.raddr   = s_if.raddr;
    assign m_if.arvalid = hold_valid && s_if.arvalid;
    assign s_if.rdata   = m_if.rdata;
    assign s_if.rvalid  = m_if.rvalid;
    assign m_if.rready  = s_if.rready;
    assign busy         = 1'b0;
  end else begin : g_pipe
    // Write chain index 0 is the s_if side; read chain index 0 is the m_if side.
    logic  w_valid [NSTG+1];
    logic  w_ready [NSTG+1];
    wreq_t w_data  [NSTG+1];
    logic  w_busy  [NSTG];
    logic  r_valid [NSTG+1];
    logic  r_ready [NSTG+1];
    rdat_t r_data  [NSTG+1];
    logic  r_busy  [NSTG];

    logic [NSTG-1:0]       ar_valid_q;
    logic [NSTG-1:0]       wresp_q;
    logic [ADDR_WIDTH-1:0] raddr_q [NSTG];
    logic                  busy_c;

    assign w_valid[0]    = hold_valid && s_if.wvalid;
    assign w_data[0]     = {s_if.waddr, s_if.wdata};
    assign s_if.wready   = w_ready[0];
    assign m_if.wvalid   = w_valid[NSTG];
    assign m_if.waddr    = w_data[NSTG].addr;
    assign m_if.wdata    = w_data[NSTG].data;
    assign w_ready[NSTG] = m_if.wready;

    assign r_valid[0]    = m_if.rvalid;
    assign r_data[0]     = m_if.rdata;
    assign m_if.rready   = r_ready[0];
    assign s_if.rvalid   = r_valid[NSTG];
    assign s_if.rdata    = r_data[NSTG].data;
    assign r_ready[NSTG] = s_if.rready;

    for (genvar i = 0; i < NSTG; i++) begin : g_stage
      ps_skid_stage #(.T(wreq_t)) u_wr (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (w_valid[i]),
        .in_ready_o  (w_ready[i]),
        .in_data_i   (w_data[i]),
        .out_valid_o (w_valid[i+1]),
        .out_ready_i (w_ready[i+1]),
        .out_data_o  (w_data[i+1]),
        .busy_o      (w_busy[i])
      );

      ps_skid_stage #(.T(rdat_t)) u_rd (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (r_valid[i]),
        .in_ready_o  (r_ready[i]),
        .in_data_i   (r_data[i]),
        .out_valid_o (r_valid[i+1]),
        .out_ready_i (r_ready[i+1]),
        .out_data_o  (r_data[i+1]),
        .busy_o      (r_busy[i])
      );
    end

    // arvalid and wresp delay lines: shift every cycle, no backpressure, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ar_valid_q <= '0;
        wresp_q    <= '0;
      end else begin
        ar_valid_q[0] <= hold_valid && s_if.arvalid;
        wresp_q[0]    <= m_if.wresp;
        for (int i = 1; i < NSTG; i++) begin
          ar_valid_q[i] <= ar_valid_q[i-1];
          wresp_q[i]    <= wresp_q[i-1];
        end
      end
    end

    // raddr travels alongside arvalid.
    always_ff @(posedge clk) begin
      raddr_q[0] <= s_if.raddr;
      for (int i = 1; i < NSTG; i++) raddr_q[i] <= raddr_q[i-1];
    end

    assign m_if.arvalid = ar_valid_q[NSTG-1];
    assign m_if.raddr   = raddr_q[NSTG-1];
    assign s_if.wresp   = wresp_q[NSTG-1];

    // busy is the OR of every stage valid flop in all four channels.
    always_comb begin
      busy_c = (|ar_valid_q) || (|wresp_q);
      for (int i = 0; i < NSTG; i++) busy_c = busy_c || w_busy[i] || r_busy[i];
    end

    assign busy = busy_c;
  end

endmodule

// File: tb/tb_ps_if_pipe_slice.sv
// Scoreboard bench for ps_if_pipe_slice at STAGES = 0, 1, 2 and 3.
module tb_ps_if_pipe_slice;

  logic clk;
  logic rst;
  logic hold;
  logic busy0, busy1, busy2, busy3;

  ps_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0 (), m0 (), s1 (), m1 (), s2 (), m2 (), s3 (), m3 ();

  ps_if_pipe_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STAGES(0)) u0 (
    .clk(clk), .rst(rst), .hold_valid(hold), .s_if(s0), .m_if(m0), .busy(busy0));
  ps_if_pipe_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .hold_valid(hold), .s_if(s1), .m_if(m1), .busy(busy1));
  ps_if_pipe_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .hold_valid(hold), .s_if(s2), .m_if(m2), .busy(busy2));
  ps_if_pipe_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STAGES(3)) u3 (
    .clk(clk), .rst(rst), .hold_valid(hold), .s_if(s3), .m_if(m3), .busy(busy3));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic        r;
  } dl_t;

  int total = 0;
  int bad   = 0;

  beat_t       wq[$];
  dl_t         dq[$];
  logic [31:0] rq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    s0.wvalid = 0; s0.arvalid = 0; s0.rready = 0; s0.waddr = 0; s0.wdata = 0; s0.raddr = 0;
    m0.wready = 0; m0.wresp = 0; m0.rvalid = 0; m0.rdata = 0;
    s1.wvalid = 0; s1.arvalid = 0; s1.rready = 0; s1.waddr = 0; s1.wdata = 0; s1.raddr = 0;
    m1.wready = 0; m1.wresp = 0; m1.rvalid = 0; m1.rdata = 0;
    s2.wvalid = 0; s2.arvalid = 0; s2.rready = 0; s2.waddr = 0; s2.wdata = 0; s2.raddr = 0;
    m2.wready = 0; m2.wresp = 0; m2.rvalid = 0; m2.rdata = 0;
    s3.wvalid = 0; s3.arvalid = 0; s3.rready = 0; s3.waddr = 0; s3.wdata = 0; s3.raddr = 0;
    m3.wready = 0; m3.wresp = 0; m3.rvalid = 0; m3.rdata = 0;
  endtask

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int          idx, pops, occ, nstall, ti, emit;
    logic        prev_stall, rdy_drop;
    logic [31:0] prev_a;
    logic [31:0] rd [6];
    beat_t       e;
    dl_t         de;
    logic [31:0] re;

    rst = 1'b1;
    hold = 1'b0;
    idle_all();

    // Reset state
    #1;
    check("rst_busy", busy3, 0);
    check("rst_s_wready", s3.wready, 0);
    check("rst_m_wvalid", m3.wvalid, 0);
    check("rst_m_arvalid", m3.arvalid, 0);
    check("rst_s_rvalid", s3.rvalid, 0);
    check("rst_s_wresp", s3.wresp, 0);
    check("rst_m_rready", m3.rready, 0);
    #21 rst = 1'b0;
    #1 check("rel_wready_pre_edge", s3.wready, 0);
    tick();
    check("rel_wready_post_edge", s3.wready, 1);
    check("rel_rready_post_edge", m1.rready, 1);

    // T1: STAGES=3, 10 back-to-back writes, beats out on cycles 3..12
    hold = 1; m3.wready = 1; idx = 0; pops = 0; wq.delete();
    for (int c = 0; c < 18; c++) begin
      s3.wvalid = (idx < 10);
      s3.waddr  = 32'(idx);
      s3.wdata  = 32'hC0DE_0000 + 32'(idx);
      #3;
      if (m3.wvalid && m3.wready) begin
        if (wq.size() == 0) check("t1_extra_beat", 1, 0);
        else begin
          e = wq.pop_front();
          check("t1_addr", m3.waddr, e.a);
          check("t1_data", m3.wdata, e.d);
          check("t1_cycle", c, 3 + pops);
        end
        pops++;
      end
      if (s3.wvalid && hold && s3.wready) begin
        wq.push_back({32'(idx), 32'hC0DE_0000 + 32'(idx)});
        idx++;
      end
      tick();
    end
    s3.wvalid = 0;
    check("t1_count", pops, 10);

    // T2: STAGES=2, 12 beats with 5-cycle downstream stall
    idx = 0; pops = 0; nstall = 0; prev_stall = 0; prev_a = 0; wq.delete();
    for (int c = 0; c < 30; c++) begin
      m2.wready = !(c >= 4 && c <= 8);
      s2.wvalid = (idx < 12);
      s2.waddr  = 32'h100 + 32'(idx);
      s2.wdata  = 32'hBEEF_0000 ^ 32'(idx * 7);
      #3;
      occ = idx - pops;
      check("t2_occ_le4", occ > 4, 0);
      if (occ >= 4) check("t2_full_wready", s2.wready, 0);
      if (prev_stall) begin
        check("t2_stall_valid", m2.wvalid, 1);
        check("t2_stall_addr", m2.waddr, prev_a);
      end
      prev_stall = m2.wvalid && !m2.wready;
      prev_a     = m2.waddr;
      if (prev_stall) nstall++;
      if (m2.wvalid && m2.wready) begin
        if (wq.size() == 0) check("t2_extra_beat", 1, 0);
        else begin
          e = wq.pop_front();
          check("t2_addr", m2.waddr, e.a);
          check("t2_data", m2.wdata, e.d);
        end
        pops++;
      end
      if (s2.wvalid && hold && s2.wready) begin
        wq.push_back({32'h100 + 32'(idx), 32'hBEEF_0000 ^ 32'(idx * 7)});
        idx++;
      end
      tick();
    end
    s2.wvalid = 0; m2.wready = 1;
    check("t2_count", pops, 12);
    check("t2_stall_cycles", nstall, 5);

    // T3: STAGES=2 read-address gating and wresp delay
    dq.delete();
    dq.push_back('0);
    dq.push_back('0);
    for (int c = 0; c < 8; c++) begin
      hold       = (c != 0);
      s2.arvalid = (c <= 1);
      s2.raddr   = (c == 0) ? 32'h40 : 32'h44;
      m2.wresp   = (c == 3);
      #3;
      dq.push_back({hold && s2.arvalid, s2.raddr, m2.wresp});
      de = dq.pop_front();
      check("t3_arvalid", m2.arvalid, de.v);
      if (de.v) check("t3_raddr", m2.raddr, de.a);
      check("t3_wresp", s2.wresp, de.r);
      tick();
    end
    s2.arvalid = 0; m2.wresp = 0; hold = 1;

    // T4: STAGES=1 read data with upstream rready toggling 1,0,1
    rd[0] = 32'hA5; rd[1] = 32'h5A; rd[2] = 32'h11; rd[3] = 32'h22; rd[4] = 32'h33; rd[5] = 32'h44;
    ti = 0; pops = 0; rdy_drop = 0; rq.delete();
    for (int c = 0; c < 30; c++) begin
      m1.rvalid = (ti < 6);
      m1.rdata  = (ti < 6) ? rd[ti] : 32'h0;
      s1.rready = (c == 1) ? 1'b0 : (c < 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (c > 20) s1.rready = 1'b1;
      #3;
      if (!m1.rready) rdy_drop = 1;
      if (s1.rvalid && s1.rready) begin
        if (rq.size() == 0) check("t4_extra_beat", 1, 0);
        else begin
          re = rq.pop_front();
          check("t4_rdata", s1.rdata, re);
        end
        pops++;
      end
      if (m1.rvalid && m1.rready) begin
        rq.push_back(rd[ti]);
        ti++;
      end
      tick();
    end
    m1.rvalid = 0; s1.rready = 0;
    check("t4_count", pops, 6);
    check("t4_rready_dropped", rdy_drop, 1);

    // T5: reset while 3 writes are in flight on STAGES=3
    m3.wready = 0;
    for (int c = 0; c < 3; c++) begin
      s3.wvalid = 1;
      s3.waddr  = 32'h200 + 32'(c);
      s3.wdata  = 32'(c);
      tick();
    end
    s3.wvalid = 0;
    #3 check("t5_busy_before", busy3, 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_wvalid", m3.wvalid, 0);
    check("t5_rst_busy", busy3, 0);
    check("t5_rst_wready", s3.wready, 0);
    m3.wready = 1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("t5_wready_pre_edge", s3.wready, 0);
    tick();
    check("t5_wready_post_edge", s3.wready, 1);
    emit = 0;
    for (int c = 0; c < 8; c++) begin
      #3;
      if (m3.wvalid) emit++;
      tick();
    end
    check("t5_no_emit", emit, 0);
    check("t5_busy_after", busy3, 0);

    // T6: STAGES=0 combinational pass-through
    for (int c = 0; c < 20; c++) begin
      hold       = 1'($urandom_range(0, 1));
      s0.wvalid  = 1'($urandom_range(0, 1));
      s0.arvalid = 1'($urandom_range(0, 1));
      s0.waddr   = $urandom;
      m0.wready  = 1'($urandom_range(0, 1));
      #1;
      check("t6_wvalid", m0.wvalid, hold && s0.wvalid);
      check("t6_arvalid", m0.arvalid, hold && s0.arvalid);
      check("t6_waddr", m0.waddr, s0.waddr);
      check("t6_wready", s0.wready, m0.wready);
      check("t6_busy", busy0, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
